// File: rtl/demux8_buf_if.sv
// Bundle of the producer handshake and the two consumer handshakes of demux8_buf.
// The slave modport is the demux's view; master is the producer/consumer side.
interface demux8_buf_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_s;

    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic [AW:0]      a_count;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [AW:0]      b_count;

    modport master (
        output in_valid, in_data, in_s, a_ready, b_ready,
        input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );

    modport slave (
        input  in_valid, in_data, in_s, a_ready, b_ready,
        output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );
endinterface

// File: rtl/demux8_buf.sv
// Buffered 1-to-2 demultiplexer: each input beat is steered by in_s into FIFO A or FIFO B,
// and each FIFO drains independently so one stalled consumer never blocks the other.
module demux8_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    demux8_buf_if.slave  bus
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] memA_q [DEPTH];
    logic [WIDTH-1:0] memB_q [DEPTH];

    logic [AW-1:0] aWrPtr_q, aWrPtr_d, aRdPtr_q, aRdPtr_d;
    logic [AW-1:0] bWrPtr_q, bWrPtr_d, bRdPtr_q, bRdPtr_d;
    logic [AW:0]   aCount_q, aCount_d, bCount_q, bCount_d;

    logic inReady;
    logic aValid, bValid;
    logic aPush, bPush, aPop, bPop;

    // Readiness looks only at the selected channel's registered count, so a pop
    // from a full channel cannot make room for a push in the same cycle.
    always_comb begin
        aValid  = (aCount_q != '0);
        bValid  = (bCount_q != '0);
        inReady = bus.in_s ? (bCount_q != FULL_CNT) : (aCount_q != FULL_CNT);
        aPush   = bus.in_valid & inReady & ~bus.in_s;
        bPush   = bus.in_valid & inReady &  bus.in_s;
        aPop    = aValid & bus.a_ready;
        bPop    = bValid & bus.b_ready;
    end

    always_comb begin
        aWrPtr_d = aWrPtr_q;
        aRdPtr_d = aRdPtr_q;
        aCount_d = aCount_q;
        bWrPtr_d = bWrPtr_q;
        bRdPtr_d = bRdPtr_q;
        bCount_d = bCount_q;

        if (aPush) aWrPtr_d = aWrPtr_q + 1'b1;
        if (aPop)  aRdPtr_d = aRdPtr_q + 1'b1;
        if (bPush) bWrPtr_d = bWrPtr_q + 1'b1;
        if (bPop)  bRdPtr_d = bRdPtr_q + 1'b1;

        case ({aPush, aPop})
            2'b10:   aCount_d = aCount_q + 1'b1;
            2'b01:   aCount_d = aCount_q - 1'b1;
            default: aCount_d = aCount_q;
        endcase

        case ({bPush, bPop})
            2'b10:   bCount_d = bCount_q + 1'b1;
            2'b01:   bCount_d = bCount_q - 1'b1;
            default: bCount_d = bCount_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aWrPtr_q <= '0;
            aRdPtr_q <= '0;
            aCount_q <= '0;
            bWrPtr_q <= '0;
            bRdPtr_q <= '0;
            bCount_q <= '0;
        end else begin
            aWrPtr_q <= aWrPtr_d;
            aRdPtr_q <= aRdPtr_d;
            aCount_q <= aCount_d;
            bWrPtr_q <= bWrPtr_d;
            bRdPtr_q <= bRdPtr_d;
            bCount_q <= bCount_d;
        end
    end

    // Storage is deliberately left out of reset; counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (aPush) memA_q[aWrPtr_q] <= bus.in_data;
        if (bPush) memB_q[bWrPtr_q] <= bus.in_data;
    end

    assign bus.in_ready = inReady;
    assign bus.a_valid  = aValid;
    assign bus.a_data   = memA_q[aRdPtr_q];
    assign bus.a_count  = aCount_q;
    assign bus.b_valid  = bValid;
    assign bus.b_data   = memB_q[bRdPtr_q];
    assign bus.b_count  = bCount_q;

endmodule
